// File: rtl/ps2_keycode_decoder_pkg.sv
// rtl/ps2_keycode_decoder_pkg.sv - shared PS/2 Set-2 constants and receiver state type
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;

   // Arrow make codes, also consumed by the character-movement block
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/ps2_keycode_decoder_if.sv
// rtl/ps2_keycode_decoder_if.sv - PS/2 pins in, decoded key state out
interface ps2_keycode_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic       extended;
   logic       key_valid;
   logic       frame_err;

   modport master (input ps2_clk, ps2_data, output keycode, extended, key_valid, frame_err);
   modport slave  (output ps2_clk, ps2_data, input keycode, extended, key_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_decoder_rx_frame.sv
// rtl/ps2_keycode_decoder_rx_frame.sv - PS/2 frame receiver with parity, stop and timeout checks
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       err
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic          clk_s1, clk_s2, clk_prev;
   logic          dat_s1, dat_s2;
   logic          fall;
   logic          timeout;
   logic          good;
   rx_state_t     state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par;
   logic [CW-1:0] idle_cnt;

   // Preset to 1 so reset never looks like a falling edge on an idle bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall    = clk_prev & ~clk_s2;
   assign timeout = (state != IDLE) && !fall && (idle_cnt == CW'(TIMEOUT_CYC - 1));
   assign good    = dat_s2 && (^{shreg, par});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
         par     <= 1'b0;
      end else if (timeout) begin
         state <= IDLE;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dat_s2) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
            end
            DATA: begin
               shreg   <= {dat_s2, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
               par   <= dat_s2;
               state <= STOP;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      idle_cnt <= '0;
      else if (state == IDLE || fall)  idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + 1'b1;
   end

   assign rx_byte  = shreg;
   assign byte_vld = (state == STOP) && fall && good;
   assign err      = ((state == STOP) && fall && !good) || timeout;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// rtl/ps2_keycode_decoder.sv - Set-2 scan code to held-keycode decoder with E0/F0 prefix handling
module ps2_keycode_decoder
   import ps2_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic          clk,
   input  logic          rst_n,
   ps2_keycode_if.master bus
);

   if (CLK_HZ <= 0) begin : g_bad_clk_hz
      $error("CLK_HZ must be positive");
   end

   logic [7:0] rx_byte;
   logic       byte_vld;
   logic       rx_err;

   logic [7:0] keycode_r, nxt_kc;
   logic       ext_r, nxt_ext;
   logic       ext_p, nxt_extp;
   logic       brk_p, nxt_brkp;
   logic       key_valid_r;
   logic       frame_err_r;

   ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .err      (rx_err)
   );

   always_comb begin
      nxt_kc   = keycode_r;
      nxt_ext  = ext_r;
      nxt_extp = ext_p;
      nxt_brkp = brk_p;
      if (rx_err) begin
         nxt_extp = 1'b0;
         nxt_brkp = 1'b0;
      end else if (byte_vld) begin
         if (rx_byte == PS2_EXT) begin
            nxt_extp = 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            nxt_brkp = 1'b1;
         end else begin
            // A break for a key other than the held one is ignored
            if (brk_p) begin
               if (rx_byte == keycode_r && ext_p == ext_r) begin
                  nxt_kc  = 8'h00;
                  nxt_ext = 1'b0;
               end
            end else begin
               nxt_kc  = rx_byte;
               nxt_ext = ext_p;
            end
            nxt_extp = 1'b0;
            nxt_brkp = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keycode_r   <= 8'h00;
         ext_r       <= 1'b0;
         ext_p       <= 1'b0;
         brk_p       <= 1'b0;
         key_valid_r <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         keycode_r   <= nxt_kc;
         ext_r       <= nxt_ext;
         ext_p       <= nxt_extp;
         brk_p       <= nxt_brkp;
         key_valid_r <= (nxt_kc != keycode_r) || (nxt_ext != ext_r);
         frame_err_r <= rx_err;
      end
   end

   assign bus.keycode   = keycode_r;
   assign bus.extended  = ext_r;
   assign bus.key_valid = key_valid_r;
   assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb/tb_ps2_keycode_decoder.sv - scoreboard bench for ps2_keycode_decoder
module tb_ps2_keycode_decoder;
   import ps2_pkg::*;

   localparam int TMO  = 300;
   localparam int HALF = 10;

   typedef struct {
      bit         is_err;
      logic [7:0] kc;
      logic       ext;
   } ev_t;

   logic clk;
   logic rst_n;
   ev_t  exp_q[$];
   int   compared;
   int   mismatched;

   ps2_keycode_if bus ();

   ps2_keycode_decoder #(.CLK_HZ(50_000_000), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      bus.ps2_data = b;
      wait_clk(HALF);
      bus.ps2_clk = 1'b0;
      wait_clk(HALF);
      bus.ps2_clk = 1'b1;
   endtask

   // nbits < 8 leaves the frame truncated after that many data bits
   task automatic send(input logic [7:0] v, input bit flip_par, input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(v[i]);
      if (nbits == 8) begin
         ps2_bit((~^v) ^ flip_par);
         ps2_bit(1'b1);
      end
      bus.ps2_data = 1'b1;
      wait_clk(2 * HALF);
   endtask

   task automatic push_key(input logic [7:0] kc, input logic ext);
      ev_t e;
      e.is_err = 1'b0;
      e.kc     = kc;
      e.ext    = ext;
      exp_q.push_back(e);
   endtask

   task automatic push_err();
      ev_t e;
      e.is_err = 1'b1;
      e.kc     = 8'h00;
      e.ext    = 1'b0;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.key_valid) begin
            if (exp_q.size() == 0) check("unexpected_key_valid", {23'd0, 1'b0, bus.keycode}, 32'hFFFF_FFFF);
            else begin
               ev_t e;
               e = exp_q.pop_front();
               check("key_event", {22'd0, 1'b0, bus.keycode, bus.extended}, {22'd0, e.is_err, e.kc, e.ext});
            end
         end
         if (bus.frame_err) begin
            if (exp_q.size() == 0) check("unexpected_frame_err", 32'd1, 32'd0);
            else begin
               ev_t e;
               e = exp_q.pop_front();
               check("err_event", {22'd0, 1'b1, 8'h00, 1'b0}, {22'd0, e.is_err, e.kc, e.ext});
            end
         end
      end
   end

   initial begin
      compared     = 0;
      mismatched   = 0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      rst_n        = 1'b0;
      wait_clk(5);
      check("rst_keycode",   {24'd0, bus.keycode}, 32'h00);
      check("rst_extended",  {31'd0, bus.extended}, 32'd0);
      check("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      rst_n = 1'b1;
      wait_clk(5);

      // Extended make then extended break
      send(PS2_EXT, 1'b0, 8);
      push_key(KEY_UP, 1'b1);
      send(KEY_UP, 1'b0, 8);
      check("ext_make_kc",  {24'd0, bus.keycode}, 32'h75);
      check("ext_make_ext", {31'd0, bus.extended}, 32'd1);
      send(PS2_EXT, 1'b0, 8);
      send(PS2_BRK, 1'b0, 8);
      push_key(8'h00, 1'b0);
      send(KEY_UP, 1'b0, 8);
      check("ext_break_kc", {24'd0, bus.keycode}, 32'h00);

      // Typematic repeats produce a single key_valid
      push_key(KEY_LEFT, 1'b0);
      for (int i = 0; i < 4; i++) send(KEY_LEFT, 1'b0, 8);
      check("typematic_kc", {24'd0, bus.keycode}, 32'h6B);
      send(PS2_BRK, 1'b0, 8);
      push_key(8'h00, 1'b0);
      send(KEY_LEFT, 1'b0, 8);

      // Parity error, then a good frame
      push_err();
      send(KEY_RIGHT, 1'b1, 8);
      check("parity_err_kc", {24'd0, bus.keycode}, 32'h00);
      push_key(KEY_RIGHT, 1'b0);
      send(KEY_RIGHT, 1'b0, 8);
      check("after_parity_kc", {24'd0, bus.keycode}, 32'h74);

      // Truncated frame times out
      push_err();
      send(KEY_DOWN, 1'b0, 5);
      wait_clk(TMO + 20);
      check("timeout_idle", {30'd0, dut.u_rx.state}, {30'd0, IDLE});
      push_key(KEY_DOWN, 1'b0);
      send(KEY_DOWN, 1'b0, 8);
      check("after_timeout_kc", {24'd0, bus.keycode}, 32'h72);

      // Release of a key that is not held
      send(PS2_EXT, 1'b0, 8);
      push_key(KEY_UP, 1'b1);
      send(KEY_UP, 1'b0, 8);
      send(PS2_BRK, 1'b0, 8);
      send(KEY_DOWN, 1'b0, 8);
      check("nonheld_brk_kc",  {24'd0, bus.keycode}, 32'h75);
      check("nonheld_brk_ext", {31'd0, bus.extended}, 32'd1);

      // Reset in the middle of a frame
      send(KEY_LEFT, 1'b0, 4);
      rst_n = 1'b0;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(5);
      check("midrst_kc",    {24'd0, bus.keycode}, 32'h00);
      check("midrst_ext",   {31'd0, bus.extended}, 32'd0);
      check("midrst_state", {30'd0, dut.u_rx.state}, {30'd0, IDLE});
      push_key(KEY_LEFT, 1'b0);
      send(KEY_LEFT, 1'b0, 8);
      check("post_rst_kc", {24'd0, bus.keycode}, 32'h6B);

      wait_clk(50);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
